// File: rtl/led_frame_sched.sv
// rtl/led_frame_sched.sv - LED strip frame scheduler: refresh pacing, filler/PHY handshake, watchdog, latch gap.
// Optional skipped-refresh counter is built only when LED_SCHED_DROP_CNT_EN is defined.
module led_frame_sched #(
    parameter int REFRESH_CYCLES = 1000000,
    parameter int LATCH_CYCLES   = 15000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int CNT_W          = 24
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       enable,
    input  logic       mean_valid,
    input  logic       send_start_in,
    input  logic       phy_done,
    output logic       fill_en,
    output logic       fill_start,
    output logic       busy,
    output logic       frame_done,
    output logic       timeout_err,
    output logic [7:0] drop_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        WAIT_DATA,
        WAIT_SEND,
        WAIT_PHY,
        LATCH,
        HOLD
    } state_t;

    localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(LATCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] LAT_PRE  = CNT_W'(LATCH_CYCLES - 2);

    state_t           state;
    logic [CNT_W-1:0] ref_cnt;
    logic [CNT_W-1:0] cnt;
    logic             frame_to;
    logic             tick;
    logic             wd_hit;

    assign tick   = (ref_cnt == REF_LAST);
    assign wd_hit = (cnt == TO_LAST);

    // Refresh timer restarts with every IDLE->ARM so the first frame sets the phase
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ref_cnt <= '0;
        end else if (!enable || state == IDLE || tick) begin
            ref_cnt <= '0;
        end else begin
            ref_cnt <= ref_cnt + 1'b1;
        end
    end

    // cnt is shared: watchdog in the WAIT_* states, gap timer in LATCH
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= IDLE;
            cnt         <= '0;
            frame_to    <= 1'b0;
            fill_en     <= 1'b0;
            fill_start  <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            fill_en    <= 1'b0;
            fill_start <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        state    <= ARM;
                        fill_en  <= 1'b1;
                        busy     <= 1'b1;
                        frame_to <= 1'b0;
                    end
                end
                ARM: begin
                    state <= WAIT_DATA;
                    cnt   <= '0;
                end
                WAIT_DATA: begin
                    if (mean_valid) begin
                        state      <= WAIT_SEND;
                        fill_start <= 1'b1;
                        cnt        <= '0;
                    end else if (wd_hit) begin
                        state       <= LATCH;
                        cnt         <= '0;
                        frame_to    <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_SEND: begin
                    if (send_start_in) begin
                        state <= WAIT_PHY;
                        cnt   <= '0;
                    end else if (wd_hit) begin
                        state       <= LATCH;
                        cnt         <= '0;
                        frame_to    <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_PHY: begin
                    // phy_done is tested first so a same-cycle expiry is not an error
                    if (phy_done) begin
                        state <= LATCH;
                        cnt   <= '0;
                    end else if (wd_hit) begin
                        state       <= LATCH;
                        cnt         <= '0;
                        frame_to    <= 1'b1;
                        timeout_err <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                LATCH: begin
                    if (cnt == LAT_PRE && !frame_to) begin
                        frame_done <= 1'b1;
                    end
                    if (cnt == LAT_LAST) begin
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= enable ? HOLD : IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (tick) begin
                        state    <= ARM;
                        fill_en  <= 1'b1;
                        busy     <= 1'b1;
                        frame_to <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
            if (!enable) begin
                timeout_err <= 1'b0;
            end
        end
    end

`ifdef LED_SCHED_DROP_CNT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            drop_cnt <= 8'd0;
        end else if (state == IDLE && enable) begin
            drop_cnt <= 8'd0;
        end else if (tick && state != HOLD && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end
`else
    assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_led_frame_sched.sv
// tb/tb_led_frame_sched.sv - self-checking bench for led_frame_sched with an event-time reference model.
`timescale 1ns/1ps
module tb_led_frame_sched;

    localparam int R = 100;
    localparam int L = 10;
    localparam int T = 50;
`ifdef LED_SCHED_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rstn, enable, mean_valid, send_start_in, phy_done;
    logic       fill_en, fill_start, busy, frame_done, timeout_err;
    logic [7:0] drop_cnt;

    int cyc = 0;
    int n_chk = 0, n_err = 0;
    int n_fe = 0, n_fs = 0, n_fd = 0, n_overlap = 0;
    int last_fe = -1, last_fs = -1, last_fd = -1;
    int exp_fe = 0, exp_fs = 0, exp_fd = 0, exp_drop = 0, exp_err = 0;
    int a = 0, hold_start = 0;

    led_frame_sched #(
        .REFRESH_CYCLES(R),
        .LATCH_CYCLES  (L),
        .TIMEOUT_CYCLES(T),
        .CNT_W         (24)
    ) dut (
        .clk          (clk),
        .rstn         (rstn),
        .enable       (enable),
        .mean_valid   (mean_valid),
        .send_start_in(send_start_in),
        .phy_done     (phy_done),
        .fill_en      (fill_en),
        .fill_start   (fill_start),
        .busy         (busy),
        .frame_done   (frame_done),
        .timeout_err  (timeout_err),
        .drop_cnt     (drop_cnt)
    );

    always #5 clk = ~clk;

    // cyc == n between edge n and edge n+1
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (fill_en === 1'b1) begin n_fe <= n_fe + 1; last_fe <= cyc; end
        if (fill_start === 1'b1) begin n_fs <= n_fs + 1; last_fs <= cyc; end
        if (frame_done === 1'b1) begin n_fd <= n_fd + 1; last_fd <= cyc; end
        if (fill_en === 1'b1 && fill_start === 1'b1) n_overlap <= n_overlap + 1;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout cycle=%0d", cyc);
        $fatal(1, "bench time limit");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic at_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic pulse(input int which, input int c);
        at_cyc(c);
        case (which)
            0: mean_valid = 1'b1;
            1: send_start_in = 1'b1;
            default: phy_done = 1'b1;
        endcase
        @(negedge clk);
        mean_valid = 1'b0;
        send_start_in = 1'b0;
        phy_done = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_fill_en"}, fill_en, 0);
        chk({tag, "_fill_start"}, fill_start, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frame_done"}, frame_done, 0);
        chk({tag, "_timeout_err"}, timeout_err, 0);
        chk({tag, "_drop_cnt"}, drop_cnt, 0);
    endtask

    // One frame starting with fill_en expected in cycle a. Events: mean_valid in cycle a+dm,
    // send_start_in dm+ds after a, phy_done dp after that (or never when hang).
    task automatic run_frame(input int dm, input int ds, input int dp, input bit hang, input bit dis_mid);
        int m, fs, s, p, l0, nd;
        bit good;
        at_cyc(a + 1);
        exp_fe++;
        chk("fill_en_cycle", last_fe, a);
        chk("fill_en_count", n_fe, exp_fe);
        chk("err_at_arm", timeout_err, exp_err);
        m  = a + dm;
        fs = m + 1;
        s  = m + ds;
        pulse(0, m);
        chk("busy_in_frame", busy, 1);
        pulse(1, s);
        exp_fs++;
        chk("fill_start_cycle", last_fs, fs);
        chk("fill_start_count", n_fs, exp_fs);
        if (dis_mid) begin
            enable = 1'b0;
            exp_err = 0;
        end
        if (hang) begin
            l0 = s + 1 + T;
            good = 1'b0;
            at_cyc(l0 - 1);
            chk("err_before_timeout", timeout_err, exp_err);
            at_cyc(l0);
            exp_err = 1;
            chk("err_timeout_rise", timeout_err, exp_err);
        end else begin
            p = s + dp;
            pulse(2, p);
            l0 = p + 1;
            good = 1'b1;
        end
        hold_start = l0 + L;
        at_cyc(hold_start);
        if (good) begin
            exp_fd++;
            chk("frame_done_cycle", last_fd, l0 + L - 1);
        end
        chk("frame_done_count", n_fd, exp_fd);
        chk("busy_after_latch", busy, 0);
        chk("err_after_latch", timeout_err, exp_err);
        // every refresh tick from a to the end of LATCH is a dropped one
        nd = dis_mid ? 0 : (hold_start - a) / R;
        exp_drop = (exp_drop + nd > 255) ? 255 : exp_drop + nd;
        chk("drop_cnt", drop_cnt, DROP_EN ? exp_drop : 0);
        a = a + R * (nd + 1);
    endtask

    initial begin
        rstn = 1'b0;
        enable = 1'b0;
        mean_valid = 1'b0;
        send_start_in = 1'b0;
        phy_done = 1'b0;
        repeat (3) @(negedge clk);
        chk_outputs_zero("reset");
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("idle_no_fill_en", n_fe, 0);

        enable = 1'b1;
        a = cyc + 1;
        run_frame(5, 20, 30, 1'b0, 1'b0);
        pulse(0, hold_start + 1);

        for (int i = 0; i < 3; i++) begin
            run_frame($urandom_range(1, 40), $urandom_range(1, 45), $urandom_range(1, 50), 1'b0, 1'b0);
        end
        run_frame(5, 20, T, 1'b0, 1'b0);
        run_frame(20, 30, 39, 1'b0, 1'b0);
        run_frame(40, 45, 40, 1'b0, 1'b0);
        run_frame(5, 20, 0, 1'b1, 1'b0);
        run_frame(5, 10, 20, 1'b0, 1'b1);

        repeat (250) @(negedge clk);
        chk("disabled_no_fill_en", n_fe, exp_fe);
        chk("disabled_busy", busy, 0);
        chk("disabled_err", timeout_err, 0);

        enable = 1'b1;
        a = cyc + 1;
        exp_drop = 0;
        at_cyc(a + 1);
        exp_fe++;
        chk("rearm_fill_en_cycle", last_fe, a);
        pulse(0, a + 3);
        exp_fs++;
        chk("fill_start_before_reset", fill_start, 1);
        #2 rstn = 1'b0;
        #1;
        chk_outputs_zero("mid_reset");
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        a = cyc + 1;
        run_frame($urandom_range(1, 40), $urandom_range(1, 45), $urandom_range(1, 50), 1'b0, 1'b0);

        chk("no_fill_overlap", n_overlap, 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/led_frame_sched.md
Name: led_frame_sched

Overview:
- Frame scheduler for the LED strip output path.
- Paces refresh at a fixed rate and arms the FIFO filler (fill_en), then releases it once new zone means are ready (fill_start).
- Tracks the filler's send_start pulse and the PHY's completion, then enforces the strip latch/reset gap before the next frame.
- Sits between main_cac (mean_valid), the FIFO filler FSM and the LED PHY.

Parameters:
- REFRESH_CYCLES, 1000000, clk cycles per refresh period (50 Hz at 50 MHz).
- LATCH_CYCLES, 15000, minimum line-idle cycles after PHY done (300 us at 50 MHz).
- TIMEOUT_CYCLES, 2000000, watchdog limit per waiting state.
- CNT_W, 24, width of the internal timers; must hold max(REFRESH_CYCLES, LATCH_CYCLES, TIMEOUT_CYCLES).

Ports:
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- enable  in  1  global LED output enable, level
- mean_valid  in  1  single-cycle pulse: new zone means stable
- send_start_in  in  1  single-cycle pulse from FIFO filler: fill complete, PHY started
- phy_done  in  1  single-cycle pulse from PHY: last bit shifted out
- fill_en  out  1  single-cycle pulse: arm the FIFO filler
- fill_start  out  1  single-cycle pulse: begin FIFO fill
- busy  out  1  high in any state except IDLE and HOLD
- frame_done  out  1  single-cycle pulse at the end of LATCH after a good frame
- timeout_err  out  1  sticky error flag; cleared only by enable low
- drop_cnt  out  8  skipped-refresh count (see Optional Feature)

Behaviour:
- Reset values: every output 0, state IDLE, all timers 0.
- Single clock domain. Reset is asynchronous assert; outputs are registered and change only on clk edges.
- Refresh timer:
  - counts 0..REFRESH_CYCLES-1 while enable=1 and wraps;
  - held at 0 while enable=0 and reset to 0 on the IDLE->ARM transition;
  - tick = cycle where timer == REFRESH_CYCLES-1.
- States and transitions:
  - IDLE: enable=1 -> ARM.
  - ARM: fill_en=1 this cycle only -> WAIT_DATA.
  - WAIT_DATA: mean_valid -> fill_start=1 for 1 cycle, then -> WAIT_SEND. mean_valid is ignored in every other state.
  - WAIT_SEND: send_start_in -> WAIT_PHY.
  - WAIT_PHY: phy_done -> LATCH.
  - LATCH: count LATCH_CYCLES cycles. On completion:
    - pulse frame_done if no timeout occurred in this frame;
    - enable=0 -> IDLE;
    - else -> HOLD.
  - HOLD: enable=0 -> IDLE; tick -> ARM.
- fill_start is asserted at least 1 cycle after fill_en, so fill_en and fill_start never overlap.
- Watchdog:
  - restarts at 0 on entry to each of WAIT_DATA, WAIT_SEND and WAIT_PHY;
  - reaching TIMEOUT_CYCLES sets timeout_err and forces -> LATCH.
- A timed-out frame gives no frame_done. The latch gap still applies.
- enable is ignored mid-frame (ARM through LATCH). The frame completes and enable is rechecked at LATCH end and in HOLD.
- Falling edge of enable clears timeout_err.
- Any tick outside HOLD is a dropped refresh. The frame is not retriggered and the next tick in HOLD starts it.
- Simultaneous events:
  - tick on the cycle LATCH completes: counts as dropped.
  - phy_done and watchdog expiry in the same cycle: phy_done wins, no error.
- Reset mid-frame: everything returns to reset values and no pulse is emitted. The downstream filler and PHY share rstn.

Optional Feature:
- Macro: LED_SCHED_DROP_CNT_EN.
- Defined: drop_cnt increments on each dropped tick and saturates at 255. It is cleared on the IDLE->ARM transition.
- Undefined: drop_cnt is tied to 0 and no counter logic is built. The port list is identical either way.

Test Plan:
All cases use REFRESH_CYCLES=100, LATCH_CYCLES=10, TIMEOUT_CYCLES=50.
- Normal frame:
  - Stimulus: enable rises, mean_valid 5 cycles after fill_en, send_start_in 20 cycles later, phy_done 30 cycles later.
  - Required: fill_en 1 cycle after enable; fill_start the cycle after mean_valid; frame_done exactly 10 cycles after phy_done; next fill_en on the tick at 100-cycle spacing.
- PHY hang:
  - Stimulus: no phy_done.
  - Required: timeout_err set 50 cycles after WAIT_PHY entry; LATCH for 10 cycles; no frame_done; next frame still arms on a tick; timeout_err stays 1.
- Slow frame:
  - Stimulus: frame spans 2 refresh ticks.
  - Required: drop_cnt=1 with the macro, 0 without; the following fill_en aligns to a tick.
- Mid-frame disable:
  - Stimulus: enable low during WAIT_PHY.
  - Required: frame completes, then LATCH, then IDLE; timeout_err cleared; no further fill_en.
- Reset mid-frame:
  - Stimulus: rstn low in WAIT_SEND.
  - Required: all outputs 0 immediately and the FSM is in IDLE. After release with enable=1, fill_en appears 1 cycle later.
- Stray pulses:
  - Stimulus: mean_valid pulse in HOLD.
  - Required: no fill_start; the next frame waits for a fresh mean_valid.
